// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter feeding a shared FIFO
// through a one-word holding register that stalls on fifo_full.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int fifo_width = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*fifo_width-1:0] data_in,
   input  logic                          fifo_full,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          fifo_write,
   output logic [fifo_width-1:0]         fifo_data_in,
   output logic [1:0]                    grant_id,
   output logic [7:0]                    stall_cnt
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOADED = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            ptr_q, ptr_d;
   logic [fifo_width-1:0] hold_data_q, hold_data_d;
   logic [1:0]            hold_id_q, hold_id_d;
   logic [7:0]            stall_cnt_q, stall_cnt_d;

   logic       win_found;
   logic [1:0] win_idx;
   logic [1:0] scan_idx;
   logic       cap_en;

   // Round-robin scan starting at ptr_q; 2-bit index wraps modulo 4.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_idx  = ptr_q;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr_q + 2'(k);
         if (!win_found && req[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   assign fifo_write = (state_q == LOADED) && !fifo_full;
   // Capture is gated by rst so ack stays low while reset is held.
   assign cap_en     = !rst && win_found && ((state_q == IDLE) || fifo_write);
   assign ack        = cap_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

   assign fifo_data_in = hold_data_q;
   assign grant_id     = hold_id_q;
   assign stall_cnt    = stall_cnt_q;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_data_d = hold_data_q;
      hold_id_d   = hold_id_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         IDLE:    if (cap_en) state_d = LOADED;
         LOADED:  if (fifo_write && !cap_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (cap_en) begin
         hold_data_d = data_in[win_idx*fifo_width +: fifo_width];
         hold_id_d   = win_idx;
         ptr_d       = win_idx + 2'd1;
      end

      if ((state_q == LOADED) && fifo_full && (stall_cnt_q != 8'hFF))
         stall_cnt_d = stall_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         hold_data_q <= '0;
         hold_id_q   <= 2'd0;
         stall_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_data_q <= hold_data_d;
         hold_id_q   <= hold_id_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of write requesters; the legal value is 4 only.
REQ-002 The module SHALL have parameter fifo_width, default 8, giving the data width in bits of each requester word and of the FIFO word.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester write request; level-sensitive; held until the matching ack.
REQ-006 data_in  input  NUM_REQ*fifo_width  packed requester words; requester i occupies bits [i*fifo_width +: fifo_width].
REQ-007 fifo_full  input  1  full flag from the shared FIFO.
REQ-008 ack  output  NUM_REQ  one-hot combinational pulse: requester word captured this cycle.
REQ-009 fifo_write  output  1  write strobe to the shared FIFO.
REQ-010 fifo_data_in  output  fifo_width  word presented to the FIFO.
REQ-011 grant_id  output  2  index of the requester whose word is in the holding register.
REQ-012 stall_cnt  output  8  saturating count of cycles blocked by fifo_full.

Function
REQ-013 The block SHALL contain a one-word holding register (hold_data, hold_id) and a 2-state FSM: IDLE (holding register empty) and LOADED (holding register valid).
REQ-014 fifo_data_in SHALL equal hold_data and grant_id SHALL equal hold_id at all times.
REQ-015 fifo_write SHALL be combinational: 1 iff state==LOADED and fifo_full==0.
REQ-016 cap_en (capture enable) SHALL be 1 iff |req and (state==IDLE or fifo_write==1).
REQ-017 Winner selection SHALL be round-robin: scan req from index ptr upward, modulo 4; the first asserted index wins.
REQ-018 When cap_en==1, ack SHALL be one-hot at the winner in the same cycle; otherwise ack SHALL be 0.
REQ-019 When cap_en==1, the next posedge SHALL load hold_data with the winner's word, hold_id with the winner's index, and ptr with (winner+1) mod 4.
REQ-020 Transitions: IDLE->LOADED on cap_en; LOADED->LOADED on (fifo_write and cap_en) or fifo_full; LOADED->IDLE on fifo_write and !cap_en.
REQ-021 Simultaneous write and capture in LOADED SHALL sustain one FIFO write per cycle with no bubble.
REQ-022 While LOADED and fifo_full==1: hold_data, hold_id and ptr SHALL stay stable, ack SHALL be 0, and no requester word SHALL be lost.
REQ-023 stall_cnt SHALL increment by 1 on each posedge where state==LOADED and fifo_full==1, and SHALL saturate at 255 (no wrap).
REQ-024 A requester that drops req before its ack SHALL simply not be selected; no error is flagged.
REQ-025 A requester's word SHALL be written to the FIFO exactly once per ack, in ack order.

Reset
REQ-026 While rst==1, asynchronously: state=IDLE, ptr=0, hold_data=0, hold_id=0, stall_cnt=0.
REQ-027 While rst==1, the outputs SHALL be fifo_write=0, ack=0, fifo_data_in=0, grant_id=0.
REQ-028 Reset during LOADED SHALL discard the held word with no FIFO write; requesters re-arbitrate from ptr=0 after reset release.

Verification
REQ-029 Reset release, req=4'b0001, data_in[7:0]=8'hA5, fifo_full=0 -> ack=0001 in cycle 0; cycle 1: fifo_write=1, fifo_data_in=A5, grant_id=0.
REQ-030 req=4'b1111 held continuously, fifo_full=0 -> acks in order 0,1,2,3,0,...; fifo_write=1 on every cycle after the first.
REQ-031 LOADED with word 8'h3C, fifo_full=1 for 5 cycles, req=4'b0010 -> fifo_write=0, ack=0, data stable at 3C, stall_cnt=5.
REQ-032 After REQ-031, fifo_full drops -> 3C written in that cycle and requester 1 acked in the same cycle.
REQ-033 fifo_full=1 held for 300 cycles while LOADED -> stall_cnt=255, no wrap.
REQ-034 rst pulse while LOADED with word 8'h77 -> no write of 77; outputs 0 immediately; after release, req=4'b1000 is acked first, and ptr becomes 0 afterwards.
